rv_inst_encoder_loader: RTL and testbench

Inverse of the main control decoder: builds 32-bit RV32I instruction words from field-level descriptors (class, rd, rs1, rs2, funct3, immediate) and writes them sequentially into instruction memory. It is the boot/test program loader in front of the single-cycle core's instruction memory. It covers the same instruction set the core decodes: lw, sw, R-type, beq/bne, I-type ALU, and jal.

---
 rtl/rv_inst_encoder_loader.sv | 160 ++++++++++++++++
 tb/tb_rv_inst_encoder_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv_inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : rv_inst_encoder_loader
// Brief    : Encodes RV32I field descriptors into instruction words and writes
//            them sequentially into instruction memory (boot/test loader).
//            Optional macro IMM_RANGE_CHECK_EN enables per-format imm checks.
// Revision : 1.0 - initial release
// ============================================================================
module rv_inst_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        op_class,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [20:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-2:0] count,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0]       c_nop       = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_word      = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_last_addr = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-2:0] c_one       = {{(ADDR_W-2){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W-2:0] r_count;
    logic              r_done;
    logic              r_err;
    logic              r_last;

    logic [31:0]       w_enc;
    logic              w_bad;
    logic              w_shift;

`ifdef IMM_RANGE_CHECK_EN
    logic              w_imm_ok;
    logic              w_sext12;
    logic              w_sext13;
`endif

    always_comb begin
        w_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        w_bad   = 1'b0;
        w_enc   = c_nop;
        case (op_class)
            3'd0: w_enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            3'd1: w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            3'd2: w_enc = {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
            3'd3: w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            3'd4: w_enc = w_shift ? {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011}
                                  : {imm[11:0], rs1, funct3, rd, 7'b0010011};
            3'd5: w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default: w_bad = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        // In range when every bit above the format's sign bit matches it.
        w_sext12 = (&imm[20:11]) || (~|imm[20:11]);
        w_sext13 = (&imm[20:12]) || (~|imm[20:12]);
        case (op_class)
            3'd0, 3'd1: w_imm_ok = w_sext12;
            3'd3:       w_imm_ok = w_sext13 && !imm[0];
            3'd4:       w_imm_ok = w_shift ? ~|imm[20:5] : w_sext12;
            3'd5:       w_imm_ok = !imm[0];
            default:    w_imm_ok = 1'b1;
        endcase
        if (!w_imm_ok) begin
            w_bad = 1'b1;
            w_enc = c_nop;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_imem_we  <= 1'b0;
            r_addr     <= c_base;
            r_wdata    <= 32'h0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
        end else if (start) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b1;
            r_imem_we  <= 1'b0;
            r_addr     <= c_base;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (in_valid && r_in_ready) begin
                        r_wdata    <= w_enc;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_imem_we  <= 1'b1;
                        r_state    <= S_WRITE;
                        if (w_bad) r_err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_imem_we <= 1'b0;
                    r_addr    <= r_addr + c_word;
                    r_count   <= r_count + c_one;
                    // Stop rather than wrap once the top word has been written.
                    if (r_last || (r_addr == c_last_addr)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_imem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Reset suppresses the strobe in the same cycle so an aborted write never lands.
    assign imem_we    = r_imem_we & ~rst;
    assign in_ready   = r_in_ready;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rv_inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_inst_encoder_loader
// Brief    : Directed self-checking bench for rv_inst_encoder_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, funct7_5;
    logic [2:0]  op_class, funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [20:0] imm;

    logic        in_ready, imem_we, done, err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;

    logic        in_ready4, imem_we4, done4, err4;
    logic [3:0]  imem_addr4;
    logic [31:0] imem_wdata4;
    logic [2:0]  count4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv_inst_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .op_class(op_class), .funct3(funct3), .funct7_5(funct7_5),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .done(done), .err(err)
    );

    rv_inst_encoder_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_last(in_last), .op_class(op_class), .funct3(funct3), .funct7_5(funct7_5),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(imem_we4), .imem_addr(imem_addr4),
        .imem_wdata(imem_wdata4), .count(count4), .done(done4), .err(err4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one descriptor, waits for acceptance, returns in the WRITE cycle.
    task automatic send(input bit sel, input logic [2:0] cls, input logic [2:0] f3,
                        input logic f75, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [20:0] im, input logic last);
        int n;
        op_class = cls; funct3 = f3; funct7_5 = f75;
        rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!(sel ? in_ready4 : in_ready) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_imem_we: got %b required 0", imem_we); end
        total++; if (imem_addr !== 10'h0) begin bad++; $display("FAIL rst_addr: got %h required 000", imem_addr); end
        total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h required 00000000", imem_wdata); end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", count); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_flags: got done=%b err=%b required 0 0", done, err); end
        // IDLE ignores in_valid
        op_class = 3'd4; funct3 = 3'd0; rd = 5'd1; rs1 = 5'd0; imm = 21'd5;
        in_valid = 1'b1;
        tick(); tick();
        total++; if (imem_we !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL idle_ignore: got we=%b ready=%b required 0 0", imem_we, in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        pulse_start();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL start_ready: got %b required 1", in_ready); end
        send(1'b0, 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
        total++; if (imem_we !== 1'b1 || imem_addr !== 10'h000) begin bad++; $display("FAIL addi_we: got we=%b addr=%h required 1 000", imem_we, imem_addr); end
        total++; if (imem_wdata !== 32'h0050_0093) begin bad++; $display("FAIL addi_word: got %h required 00500093", imem_wdata); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL write_ready: got %b required 0", in_ready); end
        send(1'b0, 3'd0, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8, 1'b0);
        total++; if (imem_wdata !== 32'h0080_A103 || imem_addr !== 10'h004) begin bad++; $display("FAIL lw_word: got %h@%h required 0080a103@004", imem_wdata, imem_addr); end
        tick();
        total++; if (count !== 9'd2 || imem_we !== 1'b0) begin bad++; $display("FAIL basic_count: got count=%0d we=%b required 2 0", count, imem_we); end
    endtask

    task automatic test_store_rtype();
        send(1'b0, 3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 21'd4, 1'b0);
        total++; if (imem_wdata !== 32'h0020_A223 || imem_addr !== 10'h008) begin bad++; $display("FAIL sw_word: got %h@%h required 0020a223@008", imem_wdata, imem_addr); end
        send(1'b0, 3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
        total++; if (imem_wdata !== 32'h0020_81B3 || imem_addr !== 10'h00C) begin bad++; $display("FAIL add_word: got %h@%h required 002081b3@00c", imem_wdata, imem_addr); end
        send(1'b0, 3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
        total++; if (imem_wdata !== 32'h4020_81B3 || imem_addr !== 10'h010) begin bad++; $display("FAIL sub_word: got %h@%h required 402081b3@010", imem_wdata, imem_addr); end
        send(1'b0, 3'd4, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 21'd3, 1'b0);
        total++; if (imem_wdata !== 32'h4033_5293 || imem_addr !== 10'h014) begin bad++; $display("FAIL srai_word: got %h@%h required 40335293@014", imem_wdata, imem_addr); end
        tick();
        total++; if (count !== 9'd6) begin bad++; $display("FAIL rtype_count: got %0d required 6", count); end
    endtask

    task automatic test_branch_jal();
        send(1'b0, 3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1F_FFFC, 1'b0);
        total++; if (imem_wdata !== 32'hFE20_8EE3 || imem_addr !== 10'h018) begin bad++; $display("FAIL beq_word: got %h@%h required fe208ee3@018", imem_wdata, imem_addr); end
        send(1'b0, 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1);
        total++; if (imem_wdata !== 32'h0080_00EF || imem_addr !== 10'h01C) begin bad++; $display("FAIL jal_word: got %h@%h required 008000ef@01c", imem_wdata, imem_addr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_early: got %b required 0", done); end
        tick();
        total++; if (done !== 1'b1 || in_ready !== 1'b0 || count !== 9'd8) begin bad++; $display("FAIL done_state: got done=%b ready=%b count=%0d required 1 0 8", done, in_ready, count); end
        in_valid = 1'b1;
        tick(); tick();
        total++; if (in_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL done_hold: got ready=%b we=%b done=%b required 0 0 1", in_ready, imem_we, done); end
        in_valid = 1'b0;
    endtask

    task automatic test_invalid();
        pulse_start();
        total++; if (imem_addr !== 10'h0 || count !== 9'd0 || done !== 1'b0) begin bad++; $display("FAIL restart: got addr=%h count=%0d done=%b required 000 0 0", imem_addr, count, done); end
        send(1'b0, 3'd7, 3'd2, 1'b1, 5'd9, 5'd9, 5'd9, 21'h1_2345, 1'b0);
        total++; if (imem_wdata !== 32'h0000_0013 || imem_we !== 1'b1) begin bad++; $display("FAIL nop_word: got %h we=%b required 00000013 1", imem_wdata, imem_we); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b required 1", err); end
        send(1'b0, 3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 21'd1, 1'b0);
        total++; if (imem_wdata !== 32'h0000_0013 || imem_addr !== 10'h004) begin bad++; $display("FAIL nop6_word: got %h@%h required 00000013@004", imem_wdata, imem_addr); end
        tick();
        total++; if (count !== 9'd2 || err !== 1'b1) begin bad++; $display("FAIL err_sticky: got count=%0d err=%b required 2 1", count, err); end
        pulse_start();
        total++; if (err !== 1'b0 || imem_addr !== 10'h0) begin bad++; $display("FAIL err_clear: got err=%b addr=%h required 0 000", err, imem_addr); end
    endtask

    task automatic test_reset_mid_write();
        send(1'b0, 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0);
        send(1'b0, 3'd4, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 21'd2, 1'b0);
        total++; if (count !== 9'd1) begin bad++; $display("FAIL pre_rst_count: got %0d required 1", count); end
        rst = 1'b1;
        #1;
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_no_strobe: got %b required 0", imem_we); end
        tick();
        rst = 1'b0;
        total++; if (count !== 9'd0 || imem_addr !== 10'h0 || in_ready !== 1'b0) begin bad++; $display("FAIL rst_abort: got count=%0d addr=%h ready=%b required 0 000 0", count, imem_addr, in_ready); end
        tick();
        total++; if (in_ready !== 1'b0 || imem_we !== 1'b0) begin bad++; $display("FAIL rst_idle: got ready=%b we=%b required 0 0", in_ready, imem_we); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w;
        logic [3:0]  exp_a;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'(i), 1'b0);
            exp_w = 32'h0000_0093 | (32'(i) << 20);
            exp_a = 4'(i * 4);
            total++; if (imem_we4 !== 1'b1 || imem_addr4 !== exp_a || imem_wdata4 !== exp_w) begin bad++; $display("FAIL wrap_write%0d: got we=%b %h@%h required 1 %h@%h", i, imem_we4, imem_wdata4, imem_addr4, exp_w, exp_a); end
        end
        tick();
        total++; if (done4 !== 1'b1 || count4 !== 3'd4 || in_ready4 !== 1'b0) begin bad++; $display("FAIL wrap_done: got done=%b count=%0d ready=%b required 1 4 0", done4, count4, in_ready4); end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_we4 !== 1'b0) begin bad++; $display("FAIL wrap_fifth%0d: got we=%b required 0", i, imem_we4); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; funct7_5 = 1'b0;
        op_class = 3'd0; funct3 = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 21'd0;
        test_reset();
        test_basic();
        test_store_rtype();
        test_branch_jal();
        test_invalid();
        test_reset_mid_write();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
